// File: rtl/pipeline_trace_buffer_if.sv
// Capture, readout and status bundle for the pipeline trace buffer.
// master drives capture/readout requests; slave is the trace buffer itself.
interface pipeline_trace_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 5,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                         arm;
  logic                         sample_valid;
  logic                         trigger;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
  logic                         rd_en;

  logic                         rd_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_data;
  logic [TS_WIDTH-1:0]          rd_ts;
  logic                         rd_is_trig;
  logic                         armed;
  logic                         triggered;
  logic                         done;
  logic [LW-1:0]                level;

  modport master (
    output arm, sample_valid, trigger, ch_data, rd_en,
    input  rd_valid, rd_data, rd_ts, rd_is_trig, armed, triggered, done, level
  );

  modport slave (
    input  arm, sample_valid, trigger, ch_data, rd_en,
    output rd_valid, rd_data, rd_ts, rd_is_trig, armed, triggered, done, level
  );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Circular pre/post-trigger capture of NUM_CH stage channels with timestamps; freezes after the window.
// Capture lands in level one edge after the sample; readout is one entry per rd_en, 1-cycle latency, no backpressure.
module pipeline_trace_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 5,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_trace_buffer_if.slave bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int DW_ALL = NUM_CH * DATA_WIDTH;
  localparam int EW     = DW_ALL + TS_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t              state, state_next;
  logic [TS_WIDTH-1:0] ts;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level, remaining, post_cnt;

  logic                restart, wr_en, wr_trig, enter_done, rd_fire;
  logic [AW-1:0]       wr_ptr_inc;
  logic [LW-1:0]       level_inc;

  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       rd_entry;

  logic                rd_valid_q, rd_is_trig_q;
  logic [DW_ALL-1:0]   rd_data_q;
  logic [TS_WIDTH-1:0] rd_ts_q;

  assign wr_ptr_inc = wr_ptr + AW'(1);
  assign level_inc  = (level == LW'(DEPTH)) ? level : level + LW'(1);
  assign rd_entry   = mem[rd_ptr];

  // arm outranks everything, so a same-cycle sample or read is dropped on restart.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    wr_en      = 1'b0;
    wr_trig    = 1'b0;
    enter_done = 1'b0;
    rd_fire    = 1'b0;
    if (bus.arm) begin
      state_next = ARMED;
      restart    = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ARMED: begin
          if (bus.sample_valid) begin
            wr_en = 1'b1;
            if (bus.trigger) begin
              wr_trig = 1'b1;
              if (POST_TRIG == 0) begin
                state_next = DONE;
                enter_done = 1'b1;
              end else begin
                state_next = POST;
              end
            end
          end
        end
        POST: begin
          if (bus.sample_valid) begin
            wr_en = 1'b1;
            if (post_cnt == LW'(1)) begin
              state_next = DONE;
              enter_done = 1'b1;
            end
          end
        end
        DONE: rd_fire = bus.rd_en && (remaining != '0);
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ts           <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      remaining    <= '0;
      post_cnt     <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_ts_q      <= '0;
      rd_is_trig_q <= 1'b0;
    end else begin
      state      <= state_next;
      ts         <= ts + TS_WIDTH'(1);
      rd_valid_q <= rd_fire;

      if (restart) begin
        wr_ptr    <= '0;
        level     <= '0;
        remaining <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr_inc;
        level  <= level_inc;
      end

      if (wr_trig) begin
        post_cnt <= LW'(POST_TRIG);
      end else if (wr_en && state == POST) begin
        post_cnt <= post_cnt - LW'(1);
      end

      // Oldest entry sits at the next write slot once the ring has wrapped.
      if (enter_done) begin
        rd_ptr    <= (level_inc == LW'(DEPTH)) ? wr_ptr_inc : '0;
        remaining <= level_inc;
      end

      if (rd_fire) begin
        rd_data_q    <= rd_entry[EW-1 -: DW_ALL];
        rd_ts_q      <= rd_entry[TS_WIDTH:1];
        rd_is_trig_q <= rd_entry[0];
        rd_ptr       <= rd_ptr + AW'(1);
        remaining    <= remaining - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {bus.ch_data, ts, wr_trig};
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_ts      = rd_ts_q;
  assign bus.rd_is_trig = rd_is_trig_q;
  assign bus.armed      = (state == ARMED) || (state == POST);
  assign bus.triggered  = (state == POST) || (state == DONE);
  assign bus.done       = (state == DONE);
  assign bus.level      = level;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer: capture, wrap, gaps, restart, timestamp wrap and reset.
module tb_pipeline_trace_buffer;
  localparam int DW  = 32;
  localparam int NCH = 2;
  localparam int DEP = 8;
  localparam int PT  = 3;
  localparam int TSW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  logic [15:0] tb_ts = '0;
  logic [15:0] exp_ts [32];

  pipeline_trace_buffer_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP), .TS_WIDTH(TSW)) bus ();

  pipeline_trace_buffer #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP), .POST_TRIG(PT), .TS_WIDTH(TSW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance one edge and mirror the free-running timestamp.
  task automatic tick;
    @(posedge clk);
    #1;
    if (reset) tb_ts = '0;
    else       tb_ts = tb_ts + 16'd1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vecs++; if (bus.rd_valid !== 1'b0) begin errs++; $display("FAIL reset_rd_valid got %0h want 0", bus.rd_valid); end
    vecs++; if (bus.rd_data !== 64'h0) begin errs++; $display("FAIL reset_rd_data got %0h want 0", bus.rd_data); end
    vecs++; if (bus.rd_ts !== 16'h0) begin errs++; $display("FAIL reset_rd_ts got %0h want 0", bus.rd_ts); end
    vecs++; if (bus.rd_is_trig !== 1'b0) begin errs++; $display("FAIL reset_rd_is_trig got %0h want 0", bus.rd_is_trig); end
    vecs++; if ({bus.armed, bus.triggered, bus.done} !== 3'b000) begin errs++; $display("FAIL reset_status got %b want 000", {bus.armed, bus.triggered, bus.done}); end
    vecs++; if (bus.level !== 4'd0) begin errs++; $display("FAIL reset_level got %0d want 0", bus.level); end
    bus.rd_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vecs++; if (bus.rd_valid !== 1'b0) begin errs++; $display("FAIL idle_rd_valid got %0h want 0", bus.rd_valid); end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_basic;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    vecs++; if (bus.armed !== 1'b1) begin errs++; $display("FAIL basic_armed got %0h want 1", bus.armed); end
    for (int i = 1; i <= 6; i++) begin
      bus.ch_data = {32'(i + 100), 32'(i)};
      bus.sample_valid = 1'b1;
      bus.trigger = (i == 3);
      exp_ts[i] = tb_ts;
      tick();
      if (i == 3) begin
        vecs++; if (bus.triggered !== 1'b1) begin errs++; $display("FAIL basic_triggered got %0h want 1", bus.triggered); end
      end
      if (i == 5) begin
        vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL basic_done_early got %0h want 0", bus.done); end
      end
    end
    bus.sample_valid = 1'b0;
    bus.trigger = 1'b0;
    vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL basic_done got %0h want 1", bus.done); end
    vecs++; if (bus.level !== 4'd6) begin errs++; $display("FAIL basic_level got %0d want 6", bus.level); end
    vecs++; if (bus.armed !== 1'b0) begin errs++; $display("FAIL basic_armed_off got %0h want 0", bus.armed); end
    bus.rd_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      vecs++; if (bus.rd_valid !== 1'b1) begin errs++; $display("FAIL basic_rd_valid[%0d] got %0h want 1", i, bus.rd_valid); end
      vecs++; if (bus.rd_data !== {32'(i + 100), 32'(i)}) begin errs++; $display("FAIL basic_rd_data[%0d] got %0h want %0h", i, bus.rd_data, {32'(i + 100), 32'(i)}); end
      vecs++; if (bus.rd_is_trig !== (i == 3)) begin errs++; $display("FAIL basic_is_trig[%0d] got %0h want %0h", i, bus.rd_is_trig, (i == 3)); end
      vecs++; if (bus.rd_ts !== exp_ts[i]) begin errs++; $display("FAIL basic_rd_ts[%0d] got %0h want %0h", i, bus.rd_ts, exp_ts[i]); end
    end
    bus.rd_en = 1'b0;
    tick();
    vecs++; if (bus.rd_valid !== 1'b0) begin errs++; $display("FAIL basic_rd_valid_drop got %0h want 0", bus.rd_valid); end
    vecs++; if (bus.rd_data !== {32'd106, 32'd6}) begin errs++; $display("FAIL basic_rd_data_hold got %0h want %0h", bus.rd_data, {32'd106, 32'd6}); end
    vecs++; if (bus.level !== 4'd6) begin errs++; $display("FAIL basic_level_hold got %0d want 6", bus.level); end
  endtask

  task automatic test_wrap;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      bus.ch_data = {32'(i + 100), 32'(i)};
      bus.sample_valid = 1'b1;
      bus.trigger = (i == 15);
      if (i <= 18) exp_ts[i] = tb_ts;
      tick();
      if (i == 17) begin
        vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL wrap_done_early got %0h want 0", bus.done); end
      end
      if (i == 18) begin
        vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL wrap_done got %0h want 1", bus.done); end
      end
    end
    bus.sample_valid = 1'b0;
    bus.trigger = 1'b0;
    vecs++; if (bus.level !== 4'd8) begin errs++; $display("FAIL wrap_level got %0d want 8", bus.level); end
    bus.rd_en = 1'b1;
    for (int i = 11; i <= 18; i++) begin
      tick();
      vecs++; if (bus.rd_valid !== 1'b1) begin errs++; $display("FAIL wrap_rd_valid[%0d] got %0h want 1", i, bus.rd_valid); end
      vecs++; if (bus.rd_data !== {32'(i + 100), 32'(i)}) begin errs++; $display("FAIL wrap_rd_data[%0d] got %0h want %0h", i, bus.rd_data, {32'(i + 100), 32'(i)}); end
      vecs++; if (bus.rd_is_trig !== (i == 15)) begin errs++; $display("FAIL wrap_is_trig[%0d] got %0h want %0h", i, bus.rd_is_trig, (i == 15)); end
      vecs++; if (bus.rd_ts !== exp_ts[i]) begin errs++; $display("FAIL wrap_rd_ts[%0d] got %0h want %0h", i, bus.rd_ts, exp_ts[i]); end
    end
    tick();
    vecs++; if (bus.rd_valid !== 1'b0) begin errs++; $display("FAIL wrap_ninth_rd got %0h want 0", bus.rd_valid); end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_gaps;
    logic [8:0] sv_pat;
    logic [8:0] tr_pat;
    logic [31:0] exp_val [8];
    logic [15:0] prev_ts;
    int n;
    sv_pat = 9'b111101001;
    tr_pat = 9'b000110000;
    n = 0;
    prev_ts = '0;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int s = 0; s < 9; s++) begin
      bus.ch_data = {32'd0, 32'(s + 1)};
      bus.sample_valid = sv_pat[s];
      bus.trigger = tr_pat[s];
      if (sv_pat[s]) begin
        exp_val[n] = 32'(s + 1);
        exp_ts[n] = tb_ts;
        n++;
      end
      tick();
      if (s == 4) begin
        vecs++; if ({bus.armed, bus.triggered} !== 2'b10) begin errs++; $display("FAIL gaps_trig_no_valid got %b want 10", {bus.armed, bus.triggered}); end
        vecs++; if (bus.level !== 4'd2) begin errs++; $display("FAIL gaps_level got %0d want 2", bus.level); end
      end
    end
    bus.sample_valid = 1'b0;
    bus.trigger = 1'b0;
    vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL gaps_done got %0h want 1", bus.done); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vecs++; if (bus.rd_data[31:0] !== exp_val[i]) begin errs++; $display("FAIL gaps_rd_data[%0d] got %0h want %0h", i, bus.rd_data[31:0], exp_val[i]); end
      vecs++; if (bus.rd_ts !== exp_ts[i]) begin errs++; $display("FAIL gaps_rd_ts[%0d] got %0h want %0h", i, bus.rd_ts, exp_ts[i]); end
      vecs++; if (bus.rd_is_trig !== (i == 2)) begin errs++; $display("FAIL gaps_is_trig[%0d] got %0h want %0h", i, bus.rd_is_trig, (i == 2)); end
      if (i == 1) begin
        vecs++; if (16'(bus.rd_ts - prev_ts) !== 16'd3) begin errs++; $display("FAIL gaps_ts_delta got %0d want 3", 16'(bus.rd_ts - prev_ts)); end
      end
      prev_ts = bus.rd_ts;
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_arm_post;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.sample_valid = 1'b1;
    bus.trigger = 1'b1;
    bus.ch_data = {32'd0, 32'd1};
    tick();
    bus.trigger = 1'b0;
    bus.ch_data = {32'd0, 32'd2};
    tick();
    vecs++; if (bus.triggered !== 1'b1) begin errs++; $display("FAIL armpost_in_post got %0h want 1", bus.triggered); end
    bus.arm = 1'b1;
    bus.ch_data = {32'd0, 32'd3};
    tick();
    bus.arm = 1'b0;
    vecs++; if (bus.level !== 4'd0) begin errs++; $display("FAIL armpost_level got %0d want 0", bus.level); end
    vecs++; if ({bus.armed, bus.triggered, bus.done} !== 3'b100) begin errs++; $display("FAIL armpost_status got %b want 100", {bus.armed, bus.triggered, bus.done}); end
    bus.ch_data = {32'd0, 32'd4};
    tick();
    bus.sample_valid = 1'b0;
    vecs++; if (bus.level !== 4'd1) begin errs++; $display("FAIL armpost_recapture got %0d want 1", bus.level); end
  endtask

  task automatic test_ts_wrap;
    logic [15:0] want [4];
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    while (tb_ts != 16'hFFFD) tick();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ch_data = {32'd0, 32'(8'h50 + i)};
      bus.sample_valid = 1'b1;
      bus.trigger = (i == 0);
      tick();
    end
    bus.sample_valid = 1'b0;
    bus.trigger = 1'b0;
    vecs++; if ({bus.done, bus.level} !== {1'b1, 4'd4}) begin errs++; $display("FAIL tswrap_done_level got %b want 10100", {bus.done, bus.level}); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if (bus.rd_ts !== want[i]) begin errs++; $display("FAIL tswrap_rd_ts[%0d] got %0h want %0h", i, bus.rd_ts, want[i]); end
      vecs++; if (bus.rd_data[31:0] !== 32'(8'h50 + i)) begin errs++; $display("FAIL tswrap_rd_data[%0d] got %0h want %0h", i, bus.rd_data[31:0], 32'(8'h50 + i)); end
    end
  endtask

  task automatic test_reset_readout;
    reset = 1'b1;
    tick();
    vecs++; if (bus.rd_valid !== 1'b0) begin errs++; $display("FAIL rstrd_rd_valid got %0h want 0", bus.rd_valid); end
    vecs++; if ({bus.armed, bus.triggered, bus.done} !== 3'b000) begin errs++; $display("FAIL rstrd_status got %b want 000", {bus.armed, bus.triggered, bus.done}); end
    vecs++; if (bus.level !== 4'd0) begin errs++; $display("FAIL rstrd_level got %0d want 0", bus.level); end
    vecs++; if (bus.rd_data !== 64'h0) begin errs++; $display("FAIL rstrd_rd_data got %0h want 0", bus.rd_data); end
    reset = 1'b0;
    tick();
    vecs++; if (bus.rd_valid !== 1'b0) begin errs++; $display("FAIL rstrd_idle_read got %0h want 0", bus.rd_valid); end
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.arm = 1'b0;
    bus.sample_valid = 1'b0;
    bus.trigger = 1'b0;
    bus.ch_data = '0;
    bus.rd_en = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_arm_post();
    test_ts_wrap();
    test_reset_readout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
